// File: rtl/regressor_gate_gen_pkg.sv
// Shared filter parameters for the DHSAF-II-CG front end: default word/tap geometry
// and the counter-width helper used for fill and active-lane counts.
package regressor_gate_gen_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_QP    = 12;
    localparam int DEF_LEN   = 8;
    localparam int DEF_CNT_W = $clog2(DEF_LEN + 1);

    function automatic int cnt_w(input int len);
        return $clog2(len + 1);
    endfunction

endpackage

// File: rtl/regressor_gate_gen_tap_mag_cmp.sv
// Per-lane magnitude gate: |sample| (WIDTH-bit unsigned, no saturation) >= thresh.
module tap_mag_cmp #(
    parameter int WIDTH = 16
) (
    input  logic signed [WIDTH-1:0] sample,
    input  logic        [WIDTH-1:0] thresh,
    output logic                    ge
);

    logic [WIDTH-1:0] mag;

    // Most-negative input negates to itself, which is exactly 2^(WIDTH-1) unsigned.
    always_comb begin
        mag = sample[WIDTH-1] ? $unsigned(-sample) : $unsigned(sample);
        ge  = (mag >= thresh);
    end

endmodule

// File: rtl/regressor_gate_gen.sv
// Regressor tapped delay line with a cycle-aligned per-lane multiplier gate mask
// (lanes off when unfilled or below the magnitude threshold).
module regressor_gate_gen
    import regressor_gate_gen_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int QP    = DEF_QP,
    parameter int LEN   = DEF_LEN
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    input  logic signed [WIDTH-1:0]   x_in,
    input  logic                      flush,
    input  logic                      gate_mode,
    input  logic        [WIDTH-1:0]   thresh,
    output logic [LEN*WIDTH-1:0]      vec_packed,
    output logic [LEN*WIDTH-1:0]      mult_out_en,
    output logic                      fill_done,
    output logic [cnt_w(LEN)-1:0]     active_count
);

    localparam int CNT_W = cnt_w(LEN);

    if (LEN < 2 || QP < 0 || QP >= WIDTH) begin : g_bad_cfg
        $error("regressor_gate_gen: invalid LEN/QP configuration");
    end

    logic signed [WIDTH-1:0] tap_p1  [LEN];
    logic signed [WIDTH-1:0] tap_nxt [LEN];
    logic [CNT_W-1:0]        fill_p1;
    logic [CNT_W-1:0]        fill_nxt;
    logic [CNT_W-1:0]        cnt_nxt;
    logic [LEN-1:0]          ge_nxt;
    logic [LEN-1:0]          en_nxt;
    logic [LEN-1:0]          en_p1;
    logic                    upd;

    // Stage 0: next tap contents and fill level (flush wins over shift, keeps the new sample)
    always_comb begin
        upd      = in_valid | flush;
        fill_nxt = fill_p1;
        for (int k = 0; k < LEN; k++) tap_nxt[k] = tap_p1[k];
        if (flush) begin
            for (int k = 0; k < LEN; k++) tap_nxt[k] = '0;
            fill_nxt = '0;
            if (in_valid) begin
                tap_nxt[0] = x_in;
                fill_nxt   = CNT_W'(1);
            end
        end else if (in_valid) begin
            tap_nxt[0] = x_in;
            for (int k = 1; k < LEN; k++) tap_nxt[k] = tap_p1[k-1];
            fill_nxt = (fill_p1 == CNT_W'(LEN)) ? fill_p1 : fill_p1 + CNT_W'(1);
        end
    end

    for (genvar k = 0; k < LEN; k++) begin : g_lane
        tap_mag_cmp #(.WIDTH(WIDTH)) u_cmp (
            .sample (tap_nxt[k]),
            .thresh (thresh),
            .ge     (ge_nxt[k])
        );
        assign vec_packed [k*WIDTH +: WIDTH] = tap_p1[k];
        assign mult_out_en[k*WIDTH +: WIDTH] = {WIDTH{en_p1[k]}};
    end

    always_comb begin
        en_nxt  = '0;
        cnt_nxt = '0;
        for (int k = 0; k < LEN; k++) begin
            en_nxt[k] = (CNT_W'(k) < fill_nxt) && (!gate_mode || ge_nxt[k]);
            cnt_nxt   = cnt_nxt + CNT_W'(en_nxt[k]);
        end
    end

    // Stage 1: taps, mask and counts registered together; idle cycles hold everything
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < LEN; k++) tap_p1[k] <= '0;
            fill_p1      <= '0;
            en_p1        <= '0;
            fill_done    <= 1'b0;
            active_count <= '0;
        end else if (upd) begin
            for (int k = 0; k < LEN; k++) tap_p1[k] <= tap_nxt[k];
            fill_p1      <= fill_nxt;
            en_p1        <= en_nxt;
            fill_done    <= (fill_nxt == CNT_W'(LEN));
            active_count <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_regressor_gate_gen.sv
// Randomized and directed bench for regressor_gate_gen against a sample-history model.
module tb_regressor_gate_gen;

    localparam int WIDTH = 16;
    localparam int LEN   = 8;
    localparam int CNT_W = $clog2(LEN + 1);

    logic                    clk = 1'b0;
    logic                    reset = 1'b0;
    logic                    in_valid = 1'b0;
    logic signed [WIDTH-1:0] x_in = '0;
    logic                    flush = 1'b0;
    logic                    gate_mode = 1'b0;
    logic [WIDTH-1:0]        thresh = '0;
    logic [LEN*WIDTH-1:0]    vec_packed;
    logic [LEN*WIDTH-1:0]    mult_out_en;
    logic                    fill_done;
    logic [CNT_W-1:0]        active_count;

    int n_chk  = 0;
    int n_fail = 0;

    // model: last LEN samples since reset/flush, newest first
    int m_tap [LEN];
    int m_fill;
    int m_en  [LEN];

    always #5 clk = ~clk;

    regressor_gate_gen #(.WIDTH(WIDTH), .QP(12), .LEN(LEN)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .x_in         (x_in),
        .flush        (flush),
        .gate_mode    (gate_mode),
        .thresh       (thresh),
        .vec_packed   (vec_packed),
        .mult_out_en  (mult_out_en),
        .fill_done    (fill_done),
        .active_count (active_count)
    );

    task automatic check(input string tag, input logic [LEN*WIDTH-1:0] obs,
                         input logic [LEN*WIDTH-1:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < LEN; k++) begin
            m_tap[k] = 0;
            m_en[k]  = 0;
        end
        m_fill = 0;
    endtask

    task automatic model_edge(input bit iv, input int x, input bit fl, input bit gm,
                              input int th);
        if (!iv && !fl) return;
        if (fl) begin
            model_clear();
            if (iv) begin
                m_tap[0] = x;
                m_fill   = 1;
            end
        end else begin
            for (int k = LEN - 1; k > 0; k--) m_tap[k] = m_tap[k-1];
            m_tap[0] = x;
            if (m_fill < LEN) m_fill++;
        end
        for (int k = 0; k < LEN; k++) begin
            int mag;
            mag = (m_tap[k] < 0) ? -m_tap[k] : m_tap[k];
            m_en[k] = (k < m_fill && (!gm || mag >= th)) ? 1 : 0;
        end
    endtask

    task automatic check_all(input string tag);
        logic [LEN*WIDTH-1:0] ev, em;
        int cnt;
        ev  = '0;
        em  = '0;
        cnt = 0;
        for (int k = 0; k < LEN; k++) begin
            ev[k*WIDTH +: WIDTH] = m_tap[k][WIDTH-1:0];
            em[k*WIDTH +: WIDTH] = m_en[k] != 0 ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
            cnt += m_en[k];
        end
        check({tag, ".vec"},  vec_packed, ev);
        check({tag, ".mask"}, mult_out_en, em);
        check({tag, ".done"}, (LEN*WIDTH)'(fill_done), (LEN*WIDTH)'(m_fill == LEN));
        check({tag, ".cnt"},  (LEN*WIDTH)'(active_count), (LEN*WIDTH)'(cnt));
    endtask

    task automatic step(input bit iv, input logic [WIDTH-1:0] x, input bit fl,
                        input bit gm, input logic [WIDTH-1:0] th, input string tag);
        @(negedge clk);
        in_valid  = iv;
        x_in      = x;
        flush     = fl;
        gate_mode = gm;
        thresh    = th;
        @(posedge clk);
        model_edge(iv, int'($signed(x)), fl, gm, int'(th));
        #1;
        check_all(tag);
    endtask

    task automatic lane(input string tag, input int k, input logic [WIDTH-1:0] exp);
        check(tag, (LEN*WIDTH)'(vec_packed[k*WIDTH +: WIDTH]), (LEN*WIDTH)'(exp));
    endtask

    initial begin
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        reset = 1'b1;

        // three samples, fill gating only
        step(1, 16'h1000, 0, 0, 16'h0000, "p3a");
        step(1, 16'h2000, 0, 0, 16'h0000, "p3b");
        step(1, 16'h3000, 0, 0, 16'h0000, "p3c");
        lane("p3.lane0", 0, 16'h3000);
        lane("p3.lane2", 2, 16'h1000);
        check("p3.count", (LEN*WIDTH)'(active_count), (LEN*WIDTH)'(3));

        // ten samples 1..10 after a flush
        step(0, 16'h0000, 1, 0, 16'h0000, "flush0");
        for (int i = 1; i <= 10; i++) begin
            step(1, WIDTH'(i), 0, 0, 16'h0000, "seq");
            if (i == 8) check("seq8.done", (LEN*WIDTH)'(fill_done), (LEN*WIDTH)'(1));
        end
        lane("seq10.lane0", 0, 16'd10);
        lane("seq10.lane7", 7, 16'd3);

        // alternating small/large magnitude with gating
        for (int i = 0; i < LEN; i++)
            step(1, (i % 2) ? 16'hF000 : 16'h0100, 0, 1, 16'h0800, "alt");
        check("alt.count", (LEN*WIDTH)'(active_count), (LEN*WIDTH)'(4));

        // idle cycles with changed threshold must not re-evaluate the mask
        step(0, 16'h0000, 0, 0, 16'h0000, "hold");

        // most-negative magnitude against boundary thresholds
        step(1, 16'h8000, 0, 1, 16'hFFFF, "neg_ffff");
        check("neg_ffff.lane0", (LEN*WIDTH)'(mult_out_en[WIDTH-1:0]), (LEN*WIDTH)'(0));
        step(1, 16'h8000, 0, 1, 16'h8000, "neg_8000");
        check("neg_8000.lane0", (LEN*WIDTH)'(mult_out_en[WIDTH-1:0]),
              (LEN*WIDTH)'(16'hFFFF));
        step(1, 16'h0000, 0, 1, 16'h0000, "zero_th0");

        // flush together with a new sample
        step(1, 16'h0AAA, 1, 0, 16'h0000, "flush_iv");
        lane("flush_iv.lane0", 0, 16'h0AAA);
        check("flush_iv.count", (LEN*WIDTH)'(active_count), (LEN*WIDTH)'(1));

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            bit iv, fl, gm;
            logic [WIDTH-1:0] x, th;
            iv = ($urandom_range(0, 9) < 7);
            fl = ($urandom_range(0, 24) == 0);
            gm = $urandom_range(0, 1);
            x  = WIDTH'($urandom);
            th = ($urandom_range(0, 7) == 0) ? WIDTH'($urandom) : WIDTH'($urandom_range(0, 16'h4000));
            if ($urandom_range(0, 3) == 0) x = WIDTH'($urandom_range(0, 16'h0800));
            step(iv, x, fl, gm, th, "rand");
        end

        // asynchronous reset mid-stream
        @(negedge clk);
        in_valid = 1'b1;
        x_in     = 16'h1234;
        flush    = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        model_clear();
        check_all("areset");
        @(negedge clk);
        reset    = 1'b1;
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) step(0, 16'h5555, 0, 1, 16'h0000, "post_rst_idle");
        step(1, 16'h0123, 0, 0, 16'h0000, "post_rst_load");

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
